// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared core types for the issue-stage hazard controller and the pipeline registers.
package issue_hazard_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_PEND = 2'd2
  } div_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/issue_hazard_ctrl_div_seq_fsm.sv
// Divider occupancy sequencer: counts the divide latency and times the done pulse
// around D-cache waits and exception aborts.
module div_seq_fsm
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mem_wait,
  input  logic       except,
  output logic       stall,
  output logic       done,
  output div_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    if (except) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !mem_wait) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            stall   = 1'b1;
          end
        end
        BUSY: begin
          // The count keeps running under a mem-wait; only the release is deferred.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            stall = 1'b1;
          end else if (!mem_wait) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DONE_PEND;
          end
        end
        DONE_PEND: begin
          if (!mem_wait) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Dual-issue hazard/stall controller: resolves load-use, pair dependency, divider
// occupancy, D-cache wait and exception flush into per-stage stall/flush strobes.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] D_master_rs,
  input  logic [4:0] D_master_rt,
  input  logic [4:0] D_slave_rs,
  input  logic [4:0] D_slave_rt,
  input  logic       D_master_reg_wen,
  input  logic [4:0] D_master_reg_waddr,
  input  logic       D_slave_valid,
  input  logic       E_master_mem_ren,
  input  logic       E_slave_mem_ren,
  input  logic [4:0] E_master_reg_waddr,
  input  logic [4:0] E_slave_reg_waddr,
  input  logic       E_div_start,
  input  logic       M_mem_req,
  input  logic       M_data_ok,
  input  logic       M_except,
  output logic       F_stall,
  output logic       D_stall,
  output logic       E_stall,
  output logic       M_stall,
  output logic       E_flush,
  output logic       M_flush,
  output logic       W_flush,
  output logic       D_flush,
  output logic       D_slave_block,
  output logic       div_busy,
  output logic       div_done
);

  function automatic logic reads_reg(input logic [4:0] waddr);
    return (waddr != REG_ZERO) &&
           (waddr == D_master_rs || waddr == D_master_rt ||
            waddr == D_slave_rs  || waddr == D_slave_rt);
  endfunction

  logic        load_use, pair_dep, mem_wait, mem_wait_q;
  logic        div_stall, div_done_raw;
  div_state_t  div_state;
  logic        f_stall, w_flush, slave_block;
  stage_ctrl_t d_ctrl, e_ctrl, m_ctrl;

  assign load_use = (E_master_mem_ren && reads_reg(E_master_reg_waddr)) ||
                    (E_slave_mem_ren  && reads_reg(E_slave_reg_waddr));

  assign pair_dep = D_slave_valid && D_master_reg_wen &&
                    (D_master_reg_waddr != REG_ZERO) &&
                    (D_master_reg_waddr == D_slave_rs || D_master_reg_waddr == D_slave_rt);

  // Wait is live in the request cycle already and drops in the data_ok cycle.
  assign mem_wait = !M_data_ok && (mem_wait_q || M_mem_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_wait_q <= 1'b0;
    else     mem_wait_q <= mem_wait && !M_except;
  end

  div_seq_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (E_div_start),
    .mem_wait (mem_wait),
    .except   (M_except),
    .stall    (div_stall),
    .done     (div_done_raw),
    .state    (div_state)
  );

  always_comb begin
    f_stall     = 1'b0;
    w_flush     = 1'b0;
    slave_block = 1'b0;
    d_ctrl      = '0;
    e_ctrl      = '0;
    m_ctrl      = '0;
    if (!rst) begin
      if (M_except) begin
        d_ctrl.flush = 1'b1;
        e_ctrl.flush = 1'b1;
        m_ctrl.flush = 1'b1;
      end else begin
        slave_block = pair_dep;
        if (mem_wait) begin
          f_stall      = 1'b1;
          d_ctrl.stall = 1'b1;
          e_ctrl.stall = 1'b1;
          m_ctrl.stall = 1'b1;
          w_flush      = 1'b1;
        end else if (div_stall) begin
          f_stall      = 1'b1;
          d_ctrl.stall = 1'b1;
          e_ctrl.stall = 1'b1;
          m_ctrl.flush = 1'b1;
        end else if (load_use) begin
          f_stall      = 1'b1;
          d_ctrl.stall = 1'b1;
          e_ctrl.flush = 1'b1;
        end
      end
    end
  end

  assign F_stall       = f_stall;
  assign D_stall       = d_ctrl.stall;
  assign E_stall       = e_ctrl.stall;
  assign M_stall       = m_ctrl.stall;
  assign D_flush       = d_ctrl.flush;
  assign E_flush       = e_ctrl.flush;
  assign M_flush       = m_ctrl.flush;
  assign W_flush       = w_flush;
  assign D_slave_block = slave_block;
  assign div_busy      = !rst && (div_state != IDLE);
  assign div_done      = !rst && div_done_raw;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed bench for issue_hazard_ctrl: a 4-cycle divider instance for most scenarios
// and a 16-cycle instance for the mid-divide exception abort.
module tb_issue_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] D_master_rs, D_master_rt, D_slave_rs, D_slave_rt;
  logic       D_master_reg_wen;
  logic [4:0] D_master_reg_waddr;
  logic       D_slave_valid;
  logic       E_master_mem_ren, E_slave_mem_ren;
  logic [4:0] E_master_reg_waddr, E_slave_reg_waddr;
  logic       E_div_start, M_mem_req, M_data_ok, M_except;

  logic a_f_stall, a_d_stall, a_e_stall, a_m_stall, a_e_flush, a_m_flush;
  logic a_w_flush, a_d_flush, a_block, a_busy, a_done;
  logic b_f_stall, b_d_stall, b_e_stall, b_m_stall, b_e_flush, b_m_flush;
  logic b_w_flush, b_d_flush, b_block, b_busy, b_done;

  // {F_stall,D_stall,E_stall,M_stall,E_flush,M_flush,W_flush,D_flush,D_slave_block,div_busy,div_done}
  logic [10:0] outs, b_outs, exp;
  int checks = 0;
  int errors = 0;

  assign outs   = {a_f_stall, a_d_stall, a_e_stall, a_m_stall, a_e_flush, a_m_flush,
                   a_w_flush, a_d_flush, a_block, a_busy, a_done};
  assign b_outs = {b_f_stall, b_d_stall, b_e_stall, b_m_stall, b_e_flush, b_m_flush,
                   b_w_flush, b_d_flush, b_block, b_busy, b_done};

  issue_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .D_master_rs(D_master_rs), .D_master_rt(D_master_rt),
    .D_slave_rs(D_slave_rs), .D_slave_rt(D_slave_rt),
    .D_master_reg_wen(D_master_reg_wen), .D_master_reg_waddr(D_master_reg_waddr),
    .D_slave_valid(D_slave_valid),
    .E_master_mem_ren(E_master_mem_ren), .E_slave_mem_ren(E_slave_mem_ren),
    .E_master_reg_waddr(E_master_reg_waddr), .E_slave_reg_waddr(E_slave_reg_waddr),
    .E_div_start(E_div_start), .M_mem_req(M_mem_req), .M_data_ok(M_data_ok),
    .M_except(M_except),
    .F_stall(a_f_stall), .D_stall(a_d_stall), .E_stall(a_e_stall), .M_stall(a_m_stall),
    .E_flush(a_e_flush), .M_flush(a_m_flush), .W_flush(a_w_flush), .D_flush(a_d_flush),
    .D_slave_block(a_block), .div_busy(a_busy), .div_done(a_done)
  );

  issue_hazard_ctrl #(.DIV_CYCLES(16)) dut16 (
    .clk(clk), .rst(rst),
    .D_master_rs(D_master_rs), .D_master_rt(D_master_rt),
    .D_slave_rs(D_slave_rs), .D_slave_rt(D_slave_rt),
    .D_master_reg_wen(D_master_reg_wen), .D_master_reg_waddr(D_master_reg_waddr),
    .D_slave_valid(D_slave_valid),
    .E_master_mem_ren(E_master_mem_ren), .E_slave_mem_ren(E_slave_mem_ren),
    .E_master_reg_waddr(E_master_reg_waddr), .E_slave_reg_waddr(E_slave_reg_waddr),
    .E_div_start(E_div_start), .M_mem_req(M_mem_req), .M_data_ok(M_data_ok),
    .M_except(M_except),
    .F_stall(b_f_stall), .D_stall(b_d_stall), .E_stall(b_e_stall), .M_stall(b_m_stall),
    .E_flush(b_e_flush), .M_flush(b_m_flush), .W_flush(b_w_flush), .D_flush(b_d_flush),
    .D_slave_block(b_block), .div_busy(b_busy), .div_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    D_master_rs = 0; D_master_rt = 0; D_slave_rs = 0; D_slave_rt = 0;
    D_master_reg_wen = 0; D_master_reg_waddr = 0; D_slave_valid = 0;
    E_master_mem_ren = 0; E_slave_mem_ren = 0;
    E_master_reg_waddr = 0; E_slave_reg_waddr = 0;
    E_div_start = 0; M_mem_req = 0; M_data_ok = 0; M_except = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    E_master_mem_ren = 1; E_master_reg_waddr = 9; D_master_rs = 9;
    M_mem_req = 1; E_div_start = 1; D_slave_valid = 1; D_master_reg_wen = 1;
    D_master_reg_waddr = 4; D_slave_rs = 4;
    #2;
    checks++;
    if (outs !== 11'b0) begin
      errors++; $display("FAIL reset_hold got %b want %b", outs, 11'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (outs !== 11'b0) begin
      errors++; $display("FAIL reset_release got %b want %b", outs, 11'b0);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      case (k)
        0: begin E_master_mem_ren = 1; E_master_reg_waddr = 5; D_slave_rs = 5; exp = 11'b11001000000; end
        1: exp = 11'b0;
        2: begin E_slave_mem_ren = 1; E_slave_reg_waddr = 17; D_master_rt = 17; exp = 11'b11001000000; end
        default: begin E_master_mem_ren = 1; E_master_reg_waddr = 0; exp = 11'b0; end
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL load_use step %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_pair_dep();
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      D_slave_valid = 1; D_master_reg_wen = 1;
      case (k)
        0: begin D_master_reg_waddr = 3; D_slave_rt = 3; exp = 11'b00000000100; end
        1: begin D_master_reg_waddr = 0; D_slave_rt = 0; exp = 11'b0; end
        default: begin D_slave_valid = 0; D_master_reg_waddr = 3; D_slave_rs = 3; exp = 11'b0; end
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL pair_dep step %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      case (k)
        0: begin M_mem_req = 1; E_master_mem_ren = 1; E_master_reg_waddr = 7; D_master_rs = 7; exp = 11'b11110010000; end
        1: begin E_master_mem_ren = 1; E_master_reg_waddr = 7; D_master_rs = 7; exp = 11'b11110010000; end
        2: begin M_data_ok = 1; E_master_mem_ren = 1; E_master_reg_waddr = 7; D_master_rs = 7; exp = 11'b11001000000; end
        3: exp = 11'b0;
        4: begin M_mem_req = 1; exp = 11'b11110010000; end
        5: begin M_except = 1; exp = 11'b00001101000; end
        default: exp = 11'b0;
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL mem_wait step %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_div();
    clear_inputs();
    E_div_start = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) E_div_start = 0;
      if (k == 0)     exp = 11'b11100100000;
      else if (k < 4) exp = 11'b11100100010;
      else if (k == 4) exp = 11'b00000000011;
      else            exp = 11'b0;
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL div cycle %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_div_mem_wait();
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      case (k)
        0: begin E_div_start = 1; exp = 11'b11100100000; end
        1, 2: exp = 11'b11100100010;
        3, 4, 5: begin M_mem_req = 1; exp = 11'b11110010010; end
        6: begin M_mem_req = 1; M_data_ok = 1; exp = 11'b00000000011; end
        default: exp = 11'b0;
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL div_mem_wait cycle %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_except();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 27; k++) begin
      clear_inputs();
      if (k == 0) begin E_div_start = 1; exp = 11'b11100100000; end
      else if (k < 6) exp = 11'b11100100010;
      else if (k == 6) begin M_except = 1; exp = 11'b00001101010; end
      else exp = 11'b0;
      @(negedge clk);
      checks++;
      if (b_outs !== exp) begin
        errors++; $display("FAIL except_mid_div cycle %0d got %b want %b", k, b_outs, exp);
      end
      next_cycle();
    end
    E_div_start = 1; M_except = 1;
    @(negedge clk);
    checks++;
    if (b_outs !== 11'b00001101000) begin
      errors++; $display("FAIL except_vs_start got %b want %b", b_outs, 11'b00001101000);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (b_outs !== 11'b0) begin
      errors++; $display("FAIL except_vs_start_after got %b want %b", b_outs, 11'b0);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    E_div_start = 1;
    for (int k = 0; k < 11; k++) begin
      if (k == 6) E_div_start = 0;
      case (k)
        0, 5:       exp = 11'b11100100000;
        1, 2, 3:    exp = 11'b11100100010;
        6, 7, 8:    exp = 11'b11100100010;
        4, 9:       exp = 11'b00000000011;
        default:    exp = 11'b0;
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL back_to_back cycle %0d got %b want %b", k, outs, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    E_div_start = 1;
    next_cycle();
    E_div_start = 0;
    M_mem_req = 1;
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 11'b0 || b_outs !== 11'b0) begin
      errors++; $display("FAIL async_reset got %b/%b want %b", outs, b_outs, 11'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (outs !== 11'b0) begin
        errors++; $display("FAIL after_reset cycle %0d got %b want %b", k, outs, 11'b0);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_pair_dep();
    test_mem_wait();
    test_div();
    test_div_mem_wait();
    test_except();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
